// File: rtl/cereal_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cereal_rx - UART receiver for the 8N1 stream produced by the cereal
// transmitter (loopback or host link).
//
// A local bit-period counter recovers the bit timing on sysclk. Each bit is
// sampled near its middle. There is no shared clock divider.
//
// Optional feature:
//   `define CEREAL_RX_PARITY_EN  adds one even-parity bit between the data
//                                 bits and the stop bit (8E1 framing).
//
// Parameters:
//   CLKS_PER_BIT  sysclk cycles per serial bit (>= 8)
//   CNT_W         bit-period counter width (2**CNT_W > CLKS_PER_BIT)
//
// Ports:
//   sysclk      in   system clock; all logic on its rising edge
//   reset       in   synchronous, active-high reset
//   rxd         in   asynchronous serial line, idles high
//   data        out  last good received byte (LSB first on the wire)
//   valid       out  one-cycle strobe; data updates in the same cycle
//   busy        out  high whenever the receiver is not idle
//   frame_err   out  one-cycle strobe when the stop bit is sampled low
//   parity_err  out  one-cycle strobe on parity mismatch (0 without parity)
// ---------------------------------------------------------------------------
module cereal_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // The start bit is checked half a bit in, so every later sample
    // lands one full bit period further, near the middle of each bit.
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frameErr_q, frameErr_d;
    logic             parityErr_q, parityErr_d;
    logic             rxMeta_q, rxSync_q;
    logic             rxS;
    logic             parMismatch;
`ifdef CEREAL_RX_PARITY_EN
    logic             parBit_q, parBit_d;
`endif

    // Two-flop synchroniser. It resets to the idle (high) level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rxd;
            rxSync_q <= rxMeta_q;
        end
    end

    assign rxS = rxSync_q;

`ifdef CEREAL_RX_PARITY_EN
    // With even parity, the XOR of all nine bits must be zero.
    assign parMismatch = ^{shift_q, parBit_q};
`else
    assign parMismatch = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
            parBit_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frameErr_q  <= frameErr_d;
            parityErr_q <= parityErr_d;
`ifdef CEREAL_RX_PARITY_EN
            parBit_q    <= parBit_d;
`endif
        end
    end

    // Next-state logic. The strobes default low, so each one is high for a
    // single cycle. The receiver returns to IDLE at mid-stop-bit, so a start
    // bit that directly follows the stop bit is still detected.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frameErr_d  = 1'b0;
        parityErr_d = 1'b0;
`ifdef CEREAL_RX_PARITY_EN
        parBit_d    = parBit_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxS) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    if (!rxS) begin
                        bitIdx_d = '0;
                        state_d  = DATA;
                    end else begin
                        // The line went back high before mid start bit,
                        // so this was a glitch and not a real start bit.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_TC) begin
                    shift_d  = {rxS, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    cnt_d    = '0;
                    if (bitIdx_q == 3'd7) begin
`ifdef CEREAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef CEREAL_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_TC) begin
                    parBit_d = rxS;
                    cnt_d    = '0;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_TC) begin
                    cnt_d = '0;
                    if (!rxS) begin
                        // A framing error takes precedence over parity.
                        // The line may be held low (a break), so wait for
                        // it to go high before looking for a new start bit.
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end else if (parMismatch) begin
                        parityErr_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frameErr_q;
    assign parity_err = parityErr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cereal_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cereal_rx - directed self-checking bench for cereal_rx.
// It runs with CLKS_PER_BIT = 16, so half a bit is 8 cycles. Build it with
// CEREAL_RX_PARITY_EN to cover the even-parity variant.
// ---------------------------------------------------------------------------
module tb_cereal_rx;

    localparam int CPB = 16;
    localparam int CW  = 5;
`ifdef CEREAL_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       sysclk;
    logic       reset;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int assertCnt = 0;
    int failCnt   = 0;

    int cycleNum       = 0;
    int validCnt       = 0;
    int feCnt          = 0;
    int peCnt          = 0;
    int bothCnt        = 0;
    int busyCnt        = 0;
    int lastValidCycle = 0;
    int prevValidCycle = 0;
    logic [7:0] dataHist [0:15];

    cereal_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (CW)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    // Free-running 100 MHz clock.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Cycle counter used to measure the spacing between valid strobes.
    always @(posedge sysclk) begin
        cycleNum <= cycleNum + 1;
    end

    // Output monitor. It samples on the falling edge, away from the edge
    // that updates the design.
    always @(negedge sysclk) begin
        if (valid) begin
            validCnt                 <= validCnt + 1;
            dataHist[validCnt % 16]  <= data;
            prevValidCycle           <= lastValidCycle;
            lastValidCycle           <= cycleNum;
        end
        if (frame_err)          feCnt   <= feCnt + 1;
        if (parity_err)         peCnt   <= peCnt + 1;
        if (valid && frame_err) bothCnt <= bothCnt + 1;
        if (busy)               busyCnt <= busyCnt + 1;
    end

    // Compare one observation against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCnt++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Hold the line at one level for a whole bit period.
    task automatic holdBit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge sysclk);
    endtask

    // Keep the line idle (high) for n cycles.
    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge sysclk);
    endtask

    // Send one frame, LSB first. With parity built in, an even-parity bit
    // goes after the data bits.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        holdBit(1'b0);
        for (int i = 0; i < 8; i++) holdBit(b[i]);
`ifdef CEREAL_RX_PARITY_EN
        holdBit(^b);
`endif
        holdBit(stopBit);
    endtask

`ifdef CEREAL_RX_PARITY_EN
    // Send a frame with the parity bit chosen by the caller.
    task automatic applyParityStimulus(input logic [7:0] b, input logic parBit);
        holdBit(1'b0);
        for (int i = 0; i < 8; i++) holdBit(b[i]);
        holdBit(parBit);
        holdBit(1'b1);
    endtask
`endif

    initial begin
        int v0;
        int f0;
        int b0;
        int d;
        int expPe;
        expPe = 0;

        rxd   = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge sysclk);
        $display("[TB] reset state");
        checkOutput("rst_data",       data,       32'h00);
        checkOutput("rst_valid",      valid,      32'h0);
        checkOutput("rst_busy",       busy,       32'h0);
        checkOutput("rst_frame_err",  frame_err,  32'h0);
        checkOutput("rst_parity_err", parity_err, 32'h0);
        reset = 1'b0;
        idle(20);

        // Single frame 0x55.
        $display("[TB] single frame 0x55");
        applyStimulus(8'h55, 1'b1);
        checkOutput("busy_after_stop", busy, 32'h0);
        idle(10);
        checkOutput("t1_valid_cnt", validCnt,    32'd1);
        checkOutput("t1_data",      data,        32'h55);
        checkOutput("t1_hist",      dataHist[0], 32'h55);
        checkOutput("t1_fe_cnt",    feCnt,       32'd0);

        // Two frames back to back with no idle gap.
        $display("[TB] back-to-back 0xA5, 0x3C");
        v0 = validCnt;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        idle(10);
        checkOutput("b2b_valid_cnt", validCnt - v0,       32'd2);
        checkOutput("b2b_first",     dataHist[v0],        32'hA5);
        checkOutput("b2b_second",    dataHist[v0 + 1],    32'h3C);
        checkOutput("b2b_data",      data,                32'h3C);
        checkOutput("b2b_spacing",   lastValidCycle - prevValidCycle, FRAME_BITS * CPB);

        // A short low glitch, shorter than half a bit.
        $display("[TB] start-bit glitch");
        v0 = validCnt;
        f0 = feCnt;
        b0 = busyCnt;
        rxd = 1'b0;
        repeat (4) @(negedge sysclk);
        idle(30);
        d = busyCnt - b0;
        checkOutput("glitch_busy_window", {31'd0, (d >= 1) && (d <= 10)}, 32'd1);
        checkOutput("glitch_no_valid",    validCnt - v0, 32'd0);
        checkOutput("glitch_no_fe",       feCnt - f0,    32'd0);
        checkOutput("glitch_busy_end",    busy,          32'h0);

        // A framing error followed by a held-low line (break).
        $display("[TB] framing error and break");
        v0 = validCnt;
        f0 = feCnt;
        applyStimulus(8'hFF, 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge sysclk);
        checkOutput("fe_pulse_cnt", feCnt - f0,    32'd1);
        checkOutput("fe_no_valid",  validCnt - v0, 32'd0);
        checkOutput("fe_data_kept", data,          32'h3C);
        checkOutput("fe_busy_brk",  busy,          32'h1);
        idle(20);
        checkOutput("fe_busy_end",  busy,          32'h0);
        checkOutput("fe_no_more",   feCnt - f0,    32'd1);
        applyStimulus(8'h12, 1'b1);
        idle(10);
        checkOutput("after_brk_data",  data,          32'h12);
        checkOutput("after_brk_valid", validCnt - v0, 32'd1);

        // Reset in the middle of the data bits of a 0x81 frame.
        $display("[TB] reset mid-frame");
        v0 = validCnt;
        f0 = feCnt;
        holdBit(1'b0);
        holdBit(1'b1);
        holdBit(1'b0);
        holdBit(1'b0);
        rxd = 1'b0;
        repeat (5) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        rxd   = 1'b1;
        checkOutput("mid_rst_data",  data,      32'h00);
        checkOutput("mid_rst_valid", valid,     32'h0);
        checkOutput("mid_rst_busy",  busy,      32'h0);
        checkOutput("mid_rst_fe",    frame_err, 32'h0);
        idle(200);
        checkOutput("mid_rst_no_valid", validCnt - v0, 32'd0);
        checkOutput("mid_rst_no_fe",    feCnt - f0,    32'd0);
        applyStimulus(8'h7E, 1'b1);
        idle(10);
        checkOutput("post_rst_data",  data,          32'h7E);
        checkOutput("post_rst_valid", validCnt - v0, 32'd1);

`ifdef CEREAL_RX_PARITY_EN
        // 0x07 has three ones, so its even-parity bit is 1.
        $display("[TB] parity checks");
        v0 = validCnt;
        applyParityStimulus(8'h07, 1'b0);
        idle(10);
        checkOutput("par_bad_pe",    peCnt,         32'd1);
        checkOutput("par_bad_valid", validCnt - v0, 32'd0);
        checkOutput("par_bad_data",  data,          32'h7E);
        applyParityStimulus(8'h07, 1'b1);
        idle(10);
        checkOutput("par_good_valid", validCnt - v0, 32'd1);
        checkOutput("par_good_data",  data,          32'h07);
        expPe = 1;
`endif

        checkOutput("pe_total",        peCnt,   expPe);
        checkOutput("never_valid_fe",  bothCnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/cereal_rx.md
Name: cereal_rx

Overview:
UART receiver that consumes the 8N1 serial stream produced by the cereal transmitter, for example on loopback or from a host link.
- Recovers bytes on sysclk using a local bit-period counter with mid-bit sampling. It does not use a shared clockdiv.
- Presents each received byte with a one-cycle valid strobe, plus busy and framing-error status.
- Default timing: 9600 baud at 50 MHz sysclk.

Parameters:
CLKS_PER_BIT, 5208, sysclk cycles per serial bit; must be >= 8.
CNT_W, 13, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
sysclk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
rxd  input  1  asynchronous serial line; idles high.
data  output  8  last good received byte, LSB first on the wire.
valid  output  1  one-cycle strobe; data is updated in the same cycle.
busy  output  1  high whenever the FSM is not in IDLE.
frame_err  output  1  one-cycle strobe when the stop bit is sampled low.
parity_err  output  1  one-cycle strobe on parity mismatch; tied 0 when the optional feature is off.

Behaviour:
- Reset: state IDLE, both synchroniser flops 1, data 0, valid 0, frame_err 0, parity_err 0, busy 0, counter 0, bit index 0, shift register 0.
- Reset mid-frame: the frame is aborted with no strobes. After reset, reception resumes on the next falling edge.
- Input: rxd passes through a 2-flop synchroniser to produce rx_s. All decisions use rx_s only.
- IDLE: when rx_s == 0, clear the counter and go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer division).
  - At terminal count with rx_s == 0: clear the counter, set bit index to 0, go to DATA.
  - At terminal count with rx_s == 1: treat as a glitch. Return to IDLE with no strobe.
- DATA: count to CLKS_PER_BIT - 1.
  - At terminal count: shift rx_s into bit 7 of the shift register (shift right), increment bit index, clear the counter.
  - After the 8th sample, go to STOP (or PARITY when the feature is enabled).
- STOP: count to CLKS_PER_BIT - 1, then sample once.
  - rx_s == 1: data <= shift register, valid = 1 for exactly one cycle, go to IDLE.
  - rx_s == 0: frame_err = 1 for one cycle, data unchanged, valid stays 0, go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. This prevents a held-low line (break) from being decoded as 0x00 frames.
- Strobe timing: valid and frame_err are registered and assert on the clock edge following the stop-sample edge. They are never high simultaneously.
- Returning to IDLE at mid-stop-bit lets a following start bit be caught with no idle gap (back-to-back frames).
- Counter arithmetic: unsigned, compared for equality to the terminal value, never wraps in normal operation. The state machine's default branch returns to IDLE.
- Latency: about 9.5 bit periods + 3 cycles from the rxd falling edge of the start bit to valid.
- Tolerance: sampling stays within the data eye for a combined baud mismatch of ±3%.

Optional Feature:
Macro CEREAL_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP. It samples one even-parity bit after a full bit period.
  - Mismatch (XOR of the 8 data bits and the parity bit == 1) pulses parity_err for one cycle, in the same cycle valid would have asserted.
  - On mismatch, valid is suppressed and data is not updated.
  - A stop-bit error still takes precedence: frame_err pulses, parity_err stays 0.
- Not defined: 8N1 only, no PARITY state, parity_err driven constant 0.

Test Plan:
- CLKS_PER_BIT=16, send 0x55 8N1 → exactly one valid pulse, data=0x55, frame_err=0, busy returns 0 at mid-stop-bit.
- Back-to-back 0xA5 then 0x3C with a single stop bit and no idle gap → two valid pulses about 10 bit periods apart, data 0xA5 then 0x3C.
- rxd low for 4 cycles then high (below the 8-cycle half bit) → no strobes, busy high for at most 10 cycles then 0.
- Send 0xFF with the stop bit forced 0, rxd then held low 40 cycles → one frame_err pulse, valid 0, data keeps its prior value, no further strobes until rxd returns high. A following 0x12 frame is then received correctly.
- Assert reset for 1 cycle mid-DATA of a 0x81 frame → all outputs 0 next cycle, no valid for that frame. The next frame 0x7E is received as 0x7E.
- With CEREAL_RX_PARITY_EN: 0x07 with parity bit 1 → valid, data=0x07. 0x07 with parity bit 0 → parity_err pulse, valid 0, data unchanged.
